// File: rtl/lifo_share_ctrl.sv
// Two-port controller for a shared register LIFO: round-robin arbitration of
// push/pop requests, overflow/underflow rejection and occupancy tracking.
module lifo_share_ctrl #(
  parameter int DW    = 11,
  parameter int DEPTH = 15,
  parameter int CW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    req_push,
  input  logic [1:0]    req_pop,
  input  logic [DW-1:0] din0,
  input  logic [DW-1:0] din1,
  output logic [1:0]    gnt,
  output logic [1:0]    err,
  output logic [1:0]    rd_valid,
  output logic [DW-1:0] rd_data,
  output logic          stk_wr_en,
  output logic          stk_rd_en,
  output logic [DW-1:0] stk_din,
  input  logic [DW-1:0] stk_dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic {ARB = 1'b0, EXEC = 1'b1} state_t;

  state_t        state, state_nxt;
  logic          rr_ptr, rr_nxt;
  logic          sel_p0, sel_nxt;
  logic          push_p0, push_nxt;
  logic          rej_p0, rej_nxt;
  logic [CW-1:0] count_nxt;
  logic [1:0]    active;
  logic          winner;
  logic [1:0]    sel_oh;

  assign full   = (count == DEPTH_C);
  assign empty  = (count == '0);
  assign active = req_push | req_pop;
  assign winner = active[rr_ptr] ? rr_ptr : ~rr_ptr;
  assign sel_oh = sel_p0 ? 2'b10 : 2'b01;

  always_comb begin
    state_nxt = state;
    rr_nxt    = rr_ptr;
    sel_nxt   = sel_p0;
    push_nxt  = push_p0;
    rej_nxt   = rej_p0;
    count_nxt = count;
    gnt       = 2'b00;
    err       = 2'b00;
    stk_wr_en = 1'b0;
    stk_rd_en = 1'b0;
    stk_din   = '0;
    case (state)
      ARB: begin
        if (|active) begin
          sel_nxt   = winner;
          // push has priority when a port asserts both; its pop stays pending
          push_nxt  = req_push[winner];
          rej_nxt   = req_push[winner] ? full : empty;
          rr_nxt    = ~winner;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        gnt       = sel_oh;
        state_nxt = ARB;
        if (rej_p0) begin
          err = sel_oh;
        end else if (push_p0) begin
          stk_wr_en = 1'b1;
          stk_din   = sel_p0 ? din1 : din0;
          count_nxt = count + CW'(1);
        end else begin
          stk_rd_en = 1'b1;
          count_nxt = count - CW'(1);
        end
      end
      default: state_nxt = ARB;
    endcase
  end

  // control state, occupancy and pop-return stage
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ARB;
      rr_ptr   <= 1'b0;
      count    <= '0;
      rd_valid <= 2'b00;
      rd_data  <= '0;
    end else begin
      state    <= state_nxt;
      rr_ptr   <= rr_nxt;
      count    <= count_nxt;
      rd_valid <= stk_rd_en ? sel_oh : 2'b00;
      if (stk_rd_en) rd_data <= stk_dout;
    end
  end

  // ARB -> EXEC decision; only read while in EXEC, which always follows ARB
  always_ff @(posedge clk) begin
    sel_p0  <= sel_nxt;
    push_p0 <= push_nxt;
    rej_p0  <= rej_nxt;
  end

endmodule

// File: tb/tb_lifo_share_ctrl.sv
// Scoreboard bench for lifo_share_ctrl: behavioural stack macro plus an
// expected-grant queue filled at stimulus time and drained on each grant.
module tb_lifo_share_ctrl;
  localparam int DW    = 11;
  localparam int DEPTH = 15;
  localparam int CW    = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    req_push = 2'b00;
  logic [1:0]    req_pop  = 2'b00;
  logic [DW-1:0] din0 = '0;
  logic [DW-1:0] din1 = '0;
  logic [1:0]    gnt, err, rd_valid;
  logic [DW-1:0] rd_data, stk_din, stk_dout;
  logic          stk_wr_en, stk_rd_en, full, empty;
  logic [CW-1:0] count;

  lifo_share_ctrl #(.DW(DW), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst(rst), .req_push(req_push), .req_pop(req_pop),
    .din0(din0), .din1(din1), .gnt(gnt), .err(err), .rd_valid(rd_valid),
    .rd_data(rd_data), .stk_wr_en(stk_wr_en), .stk_rd_en(stk_rd_en),
    .stk_din(stk_din), .stk_dout(stk_dout), .count(count), .full(full),
    .empty(empty)
  );

  always #5 clk = ~clk;

  // stack macro: top-of-stack visible combinationally
  logic [DW-1:0] mem [16];
  int sp = 0;
  always @(posedge clk) begin
    if (rst) sp <= 0;
    else if (stk_wr_en) begin
      if (sp < 16) mem[sp[3:0]] <= stk_din;
      sp <= sp + 1;
    end else if (stk_rd_en && sp > 0) sp <= sp - 1;
  end
  assign stk_dout = (sp > 0 && sp <= 16) ? mem[4'(sp - 1)] : '0;

  typedef struct {
    bit            port;
    bit            push;
    bit            rej;
    logic [DW-1:0] data;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t          sbq[$];
  logic [DW-1:0] ref_stk[$];
  int            ref_count = 0;
  bit            rr_ref = 1'b0;
  logic [DW-1:0] rd_ref = '0;
  bit            post_vld = 1'b0, post_pop = 1'b0, post_port = 1'b0;
  logic [CW-1:0] post_cnt = '0;
  int            checks = 0, errors = 0, cyc = 0, gnt_cyc = 0;
  bit            gap_chk = 1'b0;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, want, cyc);
    end
  endtask

  task automatic expect_op(input bit port, input bit push, input logic [DW-1:0] data);
    exp_t e;
    e.port = port;
    e.push = push;
    if (push) begin
      e.rej  = (ref_count == DEPTH);
      e.data = data;
      if (!e.rej) begin ref_stk.push_back(data); ref_count++; end
    end else begin
      e.rej  = (ref_count == 0);
      e.data = e.rej ? '0 : ref_stk[$];
      if (!e.rej) begin void'(ref_stk.pop_back()); ref_count--; end
    end
    e.cnt  = CW'(ref_count);
    rr_ref = ~port;
    sbq.push_back(e);
  endtask

  // predict grant order for the request vectors, then drive them
  task automatic plan(input logic [1:0] pv, input logic [1:0] qv,
                      input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    logic [1:0] pp, qq, act;
    bit w;
    pp = pv; qq = qv;
    while ((pp | qq) != 2'b00) begin
      act = pp | qq;
      w = act[rr_ref] ? rr_ref : ~rr_ref;
      if (pp[w]) begin expect_op(w, 1'b1, w ? d1 : d0); pp[w] = 1'b0; end
      else begin expect_op(w, 1'b0, '0); qq[w] = 1'b0; end
    end
    din0 = d0; din1 = d1;
    req_push = pv; req_pop = qv;
  endtask

  task automatic step();
    exp_t e;
    logic [1:0] exp_rv;
    bit keep;
    @(negedge clk);
    cyc++;
    if (rst) begin
      check_val("rst_ctl", 64'({gnt, err, rd_valid, stk_wr_en, stk_rd_en}), 64'd0);
      check_val("rst_data", 64'({rd_data, stk_din}), 64'd0);
      check_val("rst_count", 64'({count, full, empty}), 64'd1);
      sbq.delete(); ref_stk.delete();
      ref_count = 0; rr_ref = 1'b0; rd_ref = '0; post_vld = 1'b0;
    end else begin
      exp_rv = (post_vld && post_pop) ? (post_port ? 2'b10 : 2'b01) : 2'b00;
      check_val("rd_valid", 64'(rd_valid), 64'(exp_rv));
      if (post_vld) begin
        check_val("count", 64'(count), 64'(post_cnt));
        check_val("full", 64'(full), 64'(post_cnt == CW'(DEPTH)));
        check_val("empty", 64'(empty), 64'(post_cnt == '0));
        check_val("rd_data", 64'(rd_data), 64'(rd_ref));
        post_vld = 1'b0;
      end
      check_val("exclusive", 64'({($countones(gnt) > 1), stk_wr_en & stk_rd_en}), 64'd0);
      if (gnt == 2'b00) begin
        check_val("idle_strobes", 64'({err, stk_wr_en, stk_rd_en}), 64'd0);
      end else if (sbq.size() == 0) begin
        check_val("spurious_gnt", 64'(gnt), 64'd0);
      end else begin
        e = sbq.pop_front();
        if (gap_chk) check_val("gnt_gap", 64'(cyc - gnt_cyc), 64'd2);
        gnt_cyc = cyc;
        check_val("gnt", 64'(gnt), e.port ? 64'd2 : 64'd1);
        check_val("err", 64'(err), e.rej ? (e.port ? 64'd2 : 64'd1) : 64'd0);
        check_val("wr_en", 64'(stk_wr_en), 64'(e.push && !e.rej));
        check_val("rd_en", 64'(stk_rd_en), 64'(!e.push && !e.rej));
        if (e.push && !e.rej) check_val("stk_din", 64'(stk_din), 64'(e.data));
        post_vld  = 1'b1;
        post_pop  = !e.push && !e.rej;
        post_port = e.port;
        post_cnt  = e.cnt;
        if (post_pop) rd_ref = e.data;
        keep = 1'b0;
        for (int i = 0; i < sbq.size(); i++)
          if (sbq[i].port == e.port && sbq[i].push == e.push) keep = 1'b1;
        if (!keep) begin
          if (e.push) req_push[e.port] = 1'b0;
          else req_pop[e.port] = 1'b0;
        end
      end
    end
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((sbq.size() != 0 || post_vld) && n < budget) begin step(); n++; end
    if (sbq.size() != 0 || post_vld) begin
      check_val("timeout_pending", 64'(sbq.size() + int'(post_vld)), 64'd0);
      sbq.delete(); post_vld = 1'b0; req_push = 2'b00; req_pop = 2'b00;
    end
  endtask

  task automatic do_reset();
    req_push = 2'b00; req_pop = 2'b00;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
  endtask

  initial begin
    logic [1:0] pv, qv;
    int ops, n, start;

    // reset state and single push/pop round trip on port 0
    step(); step();
    rst = 1'b0;
    start = cyc;
    plan(2'b01, 2'b00, 11'h123, '0);
    wait_idle(20);
    check_val("t1_gnt_latency", 64'(gnt_cyc - start), 64'd1);
    plan(2'b00, 2'b01, '0, '0);
    wait_idle(20);
    check_val("t1_rd_data", 64'(rd_data), 64'h123);
    check_val("t1_count", 64'(count), 64'd0);

    // both ports push continuously: alternate grants, fill, then overflow
    do_reset();
    gap_chk = 1'b1;
    gnt_cyc = cyc - 1;
    for (int k = 0; k < 16; k++) expect_op(k[0], 1'b1, k[0] ? 11'h35A : 11'h0A5);
    din0 = 11'h0A5; din1 = 11'h35A;
    req_push = 2'b11;
    wait_idle(100);
    gap_chk = 1'b0;
    check_val("t2_full", 64'({full, count}), 64'h1F);

    // drain through both ports; final pop underflows
    for (int k = 0; k < 8; k++) begin
      plan(2'b00, 2'b11, '0, '0);
      wait_idle(20);
    end
    check_val("t2_empty", 64'({empty, count}), 64'h10);

    // pop on empty from each port
    plan(2'b00, 2'b01, '0, '0);
    wait_idle(20);
    plan(2'b00, 2'b10, '0, '0);
    wait_idle(20);

    // push+pop together on port 1
    plan(2'b10, 2'b10, '0, 11'h7FF);
    wait_idle(20);
    check_val("t4_rd_data", 64'(rd_data), 64'h7FF);

    // reset while a push is in EXEC
    plan(2'b01, 2'b00, 11'h155, '0);
    n = 0;
    while (!post_vld && n < 10) begin step(); n++; end
    check_val("t5_gnt_seen", 64'(post_vld), 64'd1);
    req_push = 2'b00; req_pop = 2'b00;
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (4) step();
    check_val("t5_count", 64'(count), 64'd0);
    plan(2'b01, 2'b00, 11'h2AA, '0);
    wait_idle(20);

    // random mix, push-heavy then pop-heavy
    ops = 0;
    while (ops < 1000) begin
      pv = 2'($urandom_range(0, 3));
      qv = 2'($urandom_range(0, 3));
      if (ops < 500) qv = qv & 2'($urandom_range(0, 3));
      else pv = pv & 2'($urandom_range(0, 3));
      if ((pv | qv) == 2'b00) continue;
      plan(pv, qv, DW'($urandom), DW'($urandom));
      ops += $countones(pv) + $countones(qv);
      wait_idle(40);
    end
    check_val("t6_count", 64'(count), 64'(ref_count));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
